// File: rtl/mem_dbus.sv
// Memory-stage data-bus unit: issues loads/stores on a single-beat bus and stalls the pipeline until the ack.
// Optional feature: define ALIGN_CHECK_EN to trap misaligned half/word accesses instead of ignoring low address bits.
module mem_dbus (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_wreg_i,
    input  logic [4:0]  mem_wd_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [7:0]  mem_aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_reg2_i,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        wb_wreg,
    output logic [4:0]  wb_wd,
    output logic [31:0] wb_wdata,
    output logic        stallreq,
    output logic        exc_misalign
);

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t      state, state_nx;
    size_t       size, ld_size;
    logic        is_mem, misalign_trap, issue;
    logic [1:0]  off, ld_off;
    logic [3:0]  sel;
    logic [31:0] st_data, load_data;
    logic        ld_unsigned;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin : decode
        is_mem  = 1'b1;
        size    = SZ_W;
        case (mem_aluop_i)
            OP_LB, OP_LBU, OP_SB: size = SZ_B;
            OP_LH, OP_LHU, OP_SH: size = SZ_H;
            OP_LW, OP_SW:         size = SZ_W;
            default:              is_mem = 1'b0;
        endcase

        off     = mem_addr_i[1:0];
        sel     = 4'b1111;
        st_data = mem_reg2_i;
        // Big-endian lanes: offset 0 is the most significant byte.
        case (size)
            SZ_B: begin
                sel     = 4'b1000 >> off;
                st_data = {4{mem_reg2_i[7:0]}};
            end
            SZ_H: begin
                off[0]  = 1'b0;
                sel     = off[1] ? 4'b0011 : 4'b1100;
                st_data = {2{mem_reg2_i[15:0]}};
            end
            default: off = 2'b00;
        endcase
    end

`ifdef ALIGN_CHECK_EN
    assign misalign_trap = is_mem &&
                           (((size == SZ_H) && mem_addr_i[0]) ||
                            ((size == SZ_W) && (mem_addr_i[1:0] != 2'b00)));
`else
    assign misalign_trap = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin : next_state
        state_nx = state;
        case (state)
            IDLE:    if (is_mem) state_nx = misalign_trap ? DONE : BUSY;
            BUSY:    if (dbus_ack) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin : fsm_outputs
        stallreq = 1'b0;
        issue    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    issue    = is_mem && !misalign_trap;
                    stallreq = issue;
                end
                BUSY:    stallreq = 1'b1;
                default: stallreq = 1'b0;
            endcase
        end
    end

    always_comb begin : load_extract
        case (ld_off)
            2'd0:    lane_b = dbus_rdata[31:24];
            2'd1:    lane_b = dbus_rdata[23:16];
            2'd2:    lane_b = dbus_rdata[15:8];
            default: lane_b = dbus_rdata[7:0];
        endcase
        lane_h = ld_off[1] ? dbus_rdata[15:0] : dbus_rdata[31:16];
        case (ld_size)
            SZ_B:    load_data = ld_unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_H:    load_data = ld_unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_data = dbus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin : datapath
        if (rst) begin
            dbus_req     <= 1'b0;
            dbus_we      <= 1'b0;
            dbus_addr    <= 32'h0;
            dbus_sel     <= 4'h0;
            dbus_wdata   <= 32'h0;
            wb_wreg      <= 1'b0;
            wb_wd        <= 5'h0;
            wb_wdata     <= 32'h0;
            exc_misalign <= 1'b0;
            ld_size      <= SZ_W;
            ld_off       <= 2'b00;
            ld_unsigned  <= 1'b0;
        end else begin
            exc_misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (!is_mem) begin
                        wb_wreg  <= mem_wreg_i;
                        wb_wd    <= mem_wd_i;
                        wb_wdata <= mem_wdata_i;
                    end else begin
                        wb_wreg      <= 1'b0;
                        exc_misalign <= misalign_trap;
                    end
                    if (issue) begin
                        dbus_req    <= 1'b1;
                        dbus_we     <= mem_aluop_i[3];
                        dbus_addr   <= {mem_addr_i[31:2], 2'b00};
                        dbus_sel    <= sel;
                        dbus_wdata  <= st_data;
                        ld_size     <= size;
                        ld_off      <= off;
                        ld_unsigned <= mem_aluop_i[2];
                    end
                end
                BUSY: begin
                    wb_wreg <= 1'b0;
                    if (dbus_ack) begin
                        dbus_req <= 1'b0;
                        dbus_we  <= 1'b0;
                        // dbus_we still marks the access type here: only loads write back.
                        if (!dbus_we) begin
                            wb_wreg  <= mem_wreg_i;
                            wb_wd    <= mem_wd_i;
                            wb_wdata <= load_data;
                        end
                    end
                end
                default: wb_wreg <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dbus.sv
// Self-checking bench for mem_dbus: directed table, reset corner cases and randomized ops against a lane-arithmetic model.
module tb_mem_dbus;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wreg_i;
    logic [4:0]  mem_wd_i;
    logic [31:0] mem_wdata_i;
    logic [7:0]  mem_aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_reg2_i;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_sel;
    logic        dbus_ack;
    logic        wb_wreg;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata;
    logic        stallreq, exc_misalign;

    mem_dbus dut (
        .clk(clk), .rst(rst),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .mem_aluop_i(mem_aluop_i), .mem_addr_i(mem_addr_i), .mem_reg2_i(mem_reg2_i),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_sel(dbus_sel),
        .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
        .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
        .stallreq(stallreq), .exc_misalign(exc_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_n;
    } vec_t;

    typedef struct {
        int          req_n;
        int          stall;
        int          wreg_n;
        int          exc_n;
        bit          timeout;
        bit          unstable;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] dwdata;
        logic [4:0]  wd;
        logic [31:0] wdata;
    } obs_t;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_n;
        int          e_stall;
        int          e_wreg_n;
        logic        e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_addr;
        logic [31:0] e_dwdata;
        logic [31:0] e_wbdata;
    } tcase_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic obs_t blank();
        obs_t b;
        b.req_n = 0; b.stall = 0; b.wreg_n = 0; b.exc_n = 0;
        b.timeout = 1'b0; b.unstable = 1'b0; b.we = 1'b0; b.sel = 4'h0;
        b.addr = 32'h0; b.dwdata = 32'h0; b.wd = 5'h0; b.wdata = 32'h0;
        return b;
    endfunction

    // Reference: byte count n, lane offset rounded down to n, lanes numbered from the MSB.
    function automatic obs_t model(input vec_t v);
        obs_t m;
        int n, off, k;
        bit st, sgn;
        longint unsigned mask, val, w;
        m = blank(); n = 0; st = 1'b0; sgn = 1'b0;
        case (v.op)
            8'hE0: begin n = 1; sgn = 1'b1; end
            8'hE1: begin n = 2; sgn = 1'b1; end
            8'hE3: n = 4;
            8'hE4: n = 1;
            8'hE5: n = 2;
            8'hE8: begin n = 1; st = 1'b1; end
            8'hE9: begin n = 2; st = 1'b1; end
            8'hEB: begin n = 4; st = 1'b1; end
            default: n = 0;
        endcase
        if (n == 0) begin
            m.wreg_n = int'(v.wreg); m.wd = v.wd; m.wdata = v.wdata;
            return m;
        end
`ifdef ALIGN_CHECK_EN
        if ((int'(v.addr[1:0]) % n) != 0) begin
            m.exc_n = 1;
            return m;
        end
`endif
        off  = (int'(v.addr[1:0]) / n) * n;
        mask = (64'd1 << (8 * n)) - 64'd1;
        m.req_n = 1;
        m.stall = 2 + v.wait_n;
        m.we    = st;
        m.addr  = v.addr & 32'hFFFF_FFFC;
        m.sel   = 4'(((1 << n) - 1) << (4 - off - n));
        if (st) begin
            w = 0;
            for (k = 0; k < 4 / n; k++) w = (w << (8 * n)) | (longint'(v.reg2) & mask);
            m.dwdata = 32'(w);
        end else begin
            val = (longint'(v.rdata) >> (8 * (4 - off - n))) & mask;
            if (sgn && (((val >> (8 * n - 1)) & 64'd1) != 0)) val = val | ~mask;
            m.wdata  = 32'(val);
            m.wreg_n = int'(v.wreg);
            m.wd     = v.wd;
        end
        return m;
    endfunction

    task automatic drive_nop();
        mem_aluop_i = 8'h00; mem_wreg_i = 1'b0; mem_wd_i = 5'h0;
        mem_wdata_i = 32'h0; mem_addr_i = 32'h0; mem_reg2_i = 32'h0;
    endtask

    task automatic apply(input vec_t v);
        mem_aluop_i = v.op; mem_wreg_i = v.wreg; mem_wd_i = v.wd;
        mem_wdata_i = v.wdata; mem_addr_i = v.addr; mem_reg2_i = v.reg2;
        dbus_rdata = v.rdata;
    endtask

    // Acts as the pipeline and the bus: holds the op while stalled, acks after wait_n BUSY cycles.
    task automatic run_op(input vec_t v, input bit spur, output obs_t o);
        int busy_n, tail;
        bit retired, prev_req, adv;
        o = blank(); busy_n = 0; tail = 0; retired = 1'b0; prev_req = 1'b0;
        apply(v);
        dbus_ack = 1'b0;
        for (int cyc = 0; cyc < 60 && tail < 3; cyc++) begin
            #1;
            if (stallreq) o.stall++;
            if (dbus_req) begin
                if (!prev_req) begin
                    o.req_n++;
                    o.we = dbus_we; o.sel = dbus_sel; o.addr = dbus_addr; o.dwdata = dbus_wdata;
                end else if ({dbus_we, dbus_sel, dbus_addr, dbus_wdata} !== {o.we, o.sel, o.addr, o.dwdata}) begin
                    o.unstable = 1'b1;
                end
                dbus_ack = (busy_n == v.wait_n);
                busy_n++;
            end else begin
                dbus_ack = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            prev_req = dbus_req;
            adv = !stallreq;
            @(posedge clk); #1;
            if (wb_wreg) begin
                o.wreg_n++; o.wd = wb_wd; o.wdata = wb_wdata;
            end
            if (exc_misalign) o.exc_n++;
            if (retired) tail++;
            else if (adv) begin
                retired = 1'b1; tail = 1;
                drive_nop();
            end
        end
        dbus_ack = 1'b0;
        o.timeout = !retired;
    endtask

    task automatic compare(input string tag, input obs_t a, input obs_t e);
        check({tag, " timeout"}, 32'(a.timeout), 32'd0);
        check({tag, " req_count"}, a.req_n, e.req_n);
        check({tag, " stall_cycles"}, a.stall, e.stall);
        check({tag, " wb_wreg_cycles"}, a.wreg_n, e.wreg_n);
        check({tag, " exc_cycles"}, a.exc_n, e.exc_n);
        if (e.req_n != 0) begin
            check({tag, " dbus_addr"}, a.addr, e.addr);
            check({tag, " dbus_sel"}, 32'(a.sel), 32'(e.sel));
            check({tag, " dbus_we"}, 32'(a.we), 32'(e.we));
            check({tag, " bus_unstable"}, 32'(a.unstable), 32'd0);
            if (e.we) check({tag, " dbus_wdata"}, a.dwdata, e.dwdata);
        end
        if (e.wreg_n != 0) begin
            check({tag, " wb_wd"}, 32'(a.wd), 32'(e.wd));
            check({tag, " wb_wdata"}, a.wdata, e.wdata);
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tcase_t tbl[12];
        logic [7:0] mem_ops[8];
        vec_t v;
        obs_t o, e;
        int pick;

        mem_ops = '{8'hE0, 8'hE1, 8'hE3, 8'hE4, 8'hE5, 8'hE8, 8'hE9, 8'hEB};
        //         op     addr          reg2          wr wd     wdata         rdata         w  stl wbn we  sel      addr          dbus_wdata    wb_wdata
        tbl[0]  = '{8'h21, 32'h0000_0000, 32'h0000_0000, 1'b1, 5'd3,  32'h1234_5678, 32'h0000_0000, 0, 0, 1, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678};
        tbl[1]  = '{8'hE0, 32'h0000_0100, 32'h0000_0000, 1'b1, 5'd5,  32'h0000_0000, 32'h80FF_0000, 0, 2, 1, 1'b0, 4'b1000, 32'h0000_0100, 32'h0000_0000, 32'hFFFF_FF80};
        tbl[2]  = '{8'hE9, 32'h0000_0202, 32'hAAAA_BEEF, 1'b1, 5'd7,  32'h0000_0000, 32'h0000_0000, 3, 5, 0, 1'b1, 4'b0011, 32'h0000_0200, 32'hBEEF_BEEF, 32'h0000_0000};
        tbl[3]  = '{8'hE5, 32'h0000_0004, 32'h0000_0000, 1'b1, 5'd9,  32'h0000_0000, 32'h8001_0000, 0, 2, 1, 1'b0, 4'b1100, 32'h0000_0004, 32'h0000_0000, 32'h0000_8001};
        tbl[4]  = '{8'hE0, 32'h0000_0033, 32'h0000_0000, 1'b1, 5'd10, 32'h0000_0000, 32'h0000_007F, 1, 3, 1, 1'b0, 4'b0001, 32'h0000_0030, 32'h0000_0000, 32'h0000_007F};
        tbl[5]  = '{8'hE1, 32'h0000_0012, 32'h0000_0000, 1'b1, 5'd11, 32'h0000_0000, 32'h0000_8000, 0, 2, 1, 1'b0, 4'b0011, 32'h0000_0010, 32'h0000_0000, 32'hFFFF_8000};
        tbl[6]  = '{8'hE4, 32'h0000_001D, 32'h0000_0000, 1'b1, 5'd12, 32'h0000_0000, 32'h00AB_0000, 2, 4, 1, 1'b0, 4'b0100, 32'h0000_001C, 32'h0000_0000, 32'h0000_00AB};
        tbl[7]  = '{8'hE3, 32'h0000_0040, 32'h0000_0000, 1'b1, 5'd31, 32'h0000_0000, 32'hDEAD_BEEF, 1, 3, 1, 1'b0, 4'b1111, 32'h0000_0040, 32'h0000_0000, 32'hDEAD_BEEF};
        tbl[8]  = '{8'hE8, 32'h0000_0052, 32'h1234_56C3, 1'b1, 5'd4,  32'h0000_0000, 32'h0000_0000, 0, 2, 0, 1'b1, 4'b0010, 32'h0000_0050, 32'hC3C3_C3C3, 32'h0000_0000};
        tbl[9]  = '{8'hEB, 32'h0000_0060, 32'hCAFE_F00D, 1'b1, 5'd6,  32'h0000_0000, 32'h0000_0000, 2, 4, 0, 1'b1, 4'b1111, 32'h0000_0060, 32'hCAFE_F00D, 32'h0000_0000};
        tbl[10] = '{8'h07, 32'h0000_0000, 32'h0000_0000, 1'b0, 5'd2,  32'hFFFF_FFFF, 32'h0000_0000, 0, 0, 0, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        tbl[11] = '{8'hE0, 32'h0000_0200, 32'h0000_0000, 1'b0, 5'd8,  32'h0000_0000, 32'h7F00_0000, 0, 2, 0, 1'b0, 4'b1000, 32'h0000_0200, 32'h0000_0000, 32'h0000_0000};

        // Reset with a memory op presented: everything cleared, no stall request.
        rst = 1'b1;
        dbus_ack = 1'b0; dbus_rdata = 32'h0;
        v = '{8'hE3, 32'h0000_0040, 32'h1111_1111, 1'b1, 5'd1, 32'h0, 32'h0, 0};
        apply(v);
        repeat (2) @(posedge clk);
        #1;
        check("reset dbus_req", 32'(dbus_req), 32'd0);
        check("reset dbus_we", 32'(dbus_we), 32'd0);
        check("reset dbus_addr", dbus_addr, 32'h0);
        check("reset dbus_sel", 32'(dbus_sel), 32'h0);
        check("reset dbus_wdata", dbus_wdata, 32'h0);
        check("reset wb_wreg", 32'(wb_wreg), 32'd0);
        check("reset wb_wd", 32'(wb_wd), 32'h0);
        check("reset wb_wdata", wb_wdata, 32'h0);
        check("reset exc_misalign", 32'(exc_misalign), 32'd0);
        check("reset stallreq", 32'(stallreq), 32'd0);
        rst = 1'b0;
        drive_nop();
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            v = '{tbl[i].op, tbl[i].addr, tbl[i].reg2, tbl[i].wreg, tbl[i].wd,
                  tbl[i].wdata, tbl[i].rdata, tbl[i].wait_n};
            e = blank();
            e.stall  = tbl[i].e_stall;
            e.req_n  = (tbl[i].e_stall > 0) ? 1 : 0;
            e.wreg_n = tbl[i].e_wreg_n;
            e.we     = tbl[i].e_we;
            e.sel    = tbl[i].e_sel;
            e.addr   = tbl[i].e_addr;
            e.dwdata = tbl[i].e_dwdata;
            e.wd     = tbl[i].wd;
            e.wdata  = tbl[i].e_wbdata;
            run_op(v, 1'b0, o);
            compare($sformatf("tbl%0d", i), o, e);
        end

        // Reset while BUSY, then an ack one cycle later must be ignored.
        v = '{8'hE3, 32'h0000_0080, 32'h0, 1'b1, 5'd2, 32'h0, 32'h5555_5555, 0};
        apply(v);
        dbus_ack = 1'b0;
        @(posedge clk); #1;
        check("busy_rst req_before", 32'(dbus_req), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("busy_rst dbus_req", 32'(dbus_req), 32'd0);
        check("busy_rst dbus_addr", dbus_addr, 32'h0);
        check("busy_rst wb_wreg", 32'(wb_wreg), 32'd0);
        check("busy_rst stallreq_in_reset", 32'(stallreq), 32'd0);
        rst = 1'b0;
        drive_nop();
        dbus_ack = 1'b1;
        #1;
        check("late_ack stallreq", 32'(stallreq), 32'd0);
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        check("late_ack dbus_req", 32'(dbus_req), 32'd0);
        check("late_ack wb_wreg", 32'(wb_wreg), 32'd0);
        v = '{8'h21, 32'h0, 32'h0, 1'b1, 5'd3, 32'h1234_5678, 32'h0, 0};
        run_op(v, 1'b0, o);
        compare("after_rst alu", o, model(v));

        // Misaligned half/word ops: trapped when ALIGN_CHECK_EN is defined, else low bits ignored.
        v = '{8'hE3, 32'h0000_0006, 32'h0, 1'b1, 5'd4, 32'h0, 32'h0102_0304, 0};
        run_op(v, 1'b0, o);
        compare("misalign lw6", o, model(v));
        v = '{8'hE1, 32'h0000_0101, 32'h0, 1'b1, 5'd5, 32'h0, 32'hF00D_8123, 1};
        run_op(v, 1'b0, o);
        compare("misalign lh101", o, model(v));
        v = '{8'hE9, 32'h0000_0003, 32'h0000_1234, 1'b1, 5'd6, 32'h0, 32'h0, 0};
        run_op(v, 1'b0, o);
        compare("misalign sh3", o, model(v));
        v = '{8'hEB, 32'h0000_0002, 32'h8765_4321, 1'b1, 5'd7, 32'h0, 32'h0, 2};
        run_op(v, 1'b0, o);
        compare("misalign sw2", o, model(v));

        // Random mix with spurious acks outside BUSY.
        for (int i = 0; i < 150; i++) begin
            pick = $urandom_range(0, 9);
            v.op     = (pick < 8) ? mem_ops[pick] : 8'($urandom);
            v.addr   = $urandom;
            v.reg2   = $urandom;
            v.wreg   = 1'($urandom);
            v.wd     = 5'($urandom);
            v.wdata  = $urandom;
            v.rdata  = $urandom;
            v.wait_n = $urandom_range(0, 3);
            run_op(v, 1'b1, o);
            compare($sformatf("rnd%0d op%h", i, v.op), o, model(v));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_dbus.md
MEM_DBUS -- requirements
Module: mem_dbus

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high (1 = reset).
REQ-003 mem_wreg_i / mem_wd_i / mem_wdata_i  input  1/5/32  register write enable, destination and ALU result from the EX/MEM register.
REQ-004 mem_aluop_i  input  8  operation: LB 8'hE0, LH 8'hE1, LW 8'hE3, LBU 8'hE4, LHU 8'hE5, SB 8'hE8, SH 8'hE9, SW 8'hEB; any other value is a non-memory op.
REQ-005 mem_addr_i / mem_reg2_i  input  32/32  effective address; store source data.
REQ-006 dbus_req, dbus_we  output  1/1  bus request; write strobe.
REQ-007 dbus_addr, dbus_sel, dbus_wdata  output  32/4/32  word address (bits [1:0] = 0); byte lanes; write data.
REQ-008 dbus_rdata, dbus_ack  input  32/1  read data; access complete, valid only while dbus_req = 1.
REQ-009 wb_wreg / wb_wd / wb_wdata  output  1/5/32  registered result to writeback.
REQ-010 stallreq  output  1  combinational stall request to pipeline control.
REQ-011 exc_misalign  output  1  one-cycle misaligned-access pulse (see Configuration).

Function
REQ-012 States: IDLE, BUSY, DONE.
REQ-013 IDLE + non-memory op: wb_* <= mem_*_i at each edge (1-cycle latency); stallreq = 0.
REQ-014 IDLE + memory op: stallreq = 1; at the edge, register dbus_req = 1, dbus_we (1 for stores), dbus_addr, dbus_sel, dbus_wdata; load wb_wreg <= 0; go to BUSY.
REQ-015 BUSY: stallreq = 1; bus outputs held stable; wb_wreg <= 0 at each edge until ack.
REQ-016 BUSY + dbus_ack = 1: at the edge, dbus_req <= 0 and dbus_we <= 0. Load: wb_wreg <= mem_wreg_i, wb_wd <= mem_wd_i, wb_wdata <= extracted data. Store: wb_wreg <= 0. Go to DONE.
REQ-017 DONE: stallreq = 0; no bus access; at the edge, wb_wreg <= 0 and go to IDLE. The held instruction is never reissued.
REQ-018 Lane mapping is big-endian. Byte at addr[1:0] = 00 uses bits [31:24]. SB sel = 1000/0100/0010/0001 for offsets 0..3. SH sel = 1100 (offset 0) or 0011 (offset 2). SW sel = 1111.
REQ-019 Store data replicates the source: SB {4{reg2[7:0]}}; SH {2{reg2[15:0]}}; SW reg2.
REQ-020 Load extraction takes the selected lane. LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
REQ-021 dbus_ack while state is IDLE or DONE is ignored.
REQ-022 Minimum memory-op occupancy is 3 cycles (IDLE, BUSY with ack, DONE); each extra wait cycle adds one BUSY cycle.

Reset
REQ-023 On rst = 1 at an edge the following are cleared: state to IDLE; dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata to 0; wb_wreg to 0; wb_wd to 5'h0; wb_wdata to 32'h0; exc_misalign to 0. This applies even in BUSY: an in-flight access is abandoned and a later ack is ignored.
REQ-024 stallreq = 0 during reset.

Configuration
REQ-025 Macro ALIGN_CHECK_EN. When defined, a misaligned op in IDLE is detected: LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0. For that op: no bus access, wb_wreg <= 0, exc_misalign pulses 1 for one cycle, state goes directly to DONE, and stallreq = 0 for that op.
REQ-026 When ALIGN_CHECK_EN is undefined, the low address bits are ignored for half/word ops (addr[0], or addr[1:0], treated as 0) and exc_misalign is constant 0.

Verification
REQ-027 ALU op 8'h21 with wd = 5'd3, wdata = 32'h1234_5678 -> next cycle wb_wreg = 1, wb_wd = 3, wb_wdata = 32'h1234_5678; stallreq stays 0.
REQ-028 LB addr 32'h100 (ack in first BUSY cycle, rdata 32'h80FF_0000) -> dbus_sel = 1000, stallreq high 2 cycles, wb_wdata = 32'hFFFF_FF80, wb_wreg high exactly 1 cycle.
REQ-029 SH addr 32'h202, reg2 = 32'hAAAA_BEEF, ack delayed 3 cycles -> dbus_we = 1, sel = 0011, wdata = 32'hBEEF_BEEF, dbus_addr = 32'h200 held stable, wb_wreg never 1.
REQ-030 LHU addr 32'h4 with rdata 32'h8001_0000 -> wb_wdata = 32'h0000_8001.
REQ-031 rst asserted in BUSY, ack arriving the cycle after -> dbus_req = 0 after the edge, wb_wreg stays 0, state IDLE.
REQ-032 ALIGN_CHECK_EN defined, LW addr 32'h6 -> no dbus_req, exc_misalign = 1 for one cycle, wb_wreg = 0.
